ga23_rom_arb: RTL and testbench
===============================

GA23_ROM_ARB -- requirements
Module: ga23_rom_arb

Interface
REQ-001 Parameter BASE, default 25'h0, byte base address of the tile ROM region in SDRAM.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset: one clock; asynchronous and active-low.
REQ-004 inv  input  1  synchronous cache invalidate, active-high.
REQ-005 addr_a..addr_d  input  22 each  per-port 32-bit word address.
REQ-006 req_a..req_d  input  1 each  per-port request toggle.
REQ-007 rdy_a..rdy_d  output  1 each  per-port completion toggle.
REQ-008 data_a..data_d  output  32 each  per-port returned word.
REQ-009 sdr_addr  output  25  SDRAM byte address, 8-byte aligned.
REQ-010 sdr_req  output  1  SDRAM request toggle.
REQ-011 sdr_rdy  input  1  SDRAM completion toggle.
REQ-012 sdr_data  input  64  SDRAM line data, valid when sdr_rdy equals sdr_req.

Function
REQ-013 Port x SHALL be pending while req_x != rdy_x; addr_x SHALL be held stable by the requester while pending.
REQ-014 FSM states: IDLE, WAIT; the block SHALL serve exactly one port at a time.
REQ-015 In IDLE, the winner among pending ports SHALL be chosen round-robin, starting at the port after the last granted one; pointer resets to port a.
REQ-016 Per port, the block SHALL keep one cached 64-bit line: valid bit, tag addr[21:1], data.
REQ-017 Hit (valid, tag == addr_x[21:1]) in IDLE: at that edge data_x <= addr_x[0] ? line[63:32] : line[31:0], rdy_x toggles, pointer advances, and the state stays IDLE.
REQ-018 Miss in IDLE: at that edge sdr_addr <= BASE + {addr_x[21:1], 3'b000} (25-bit wrap), sdr_req toggles, the port index and addr[0] are latched, and the state goes to WAIT.
REQ-019 In WAIT, when sdr_rdy == sdr_req, at that edge the block SHALL:
- store sdr_data into the port line, set tag and valid;
- drive data_x with the selected half;
- toggle rdy_x, advance the pointer, and return to IDLE.
REQ-020 Miss latency: rdy_x SHALL toggle on the edge on which sdr_rdy matching is sampled; hit latency SHALL be 1 clock after req_x toggle is presented.
REQ-021 A requester toggling req_x again while pending violates the protocol; the block SHALL take no action until that port is served.
REQ-022 inv SHALL clear all valid bits at the next edge. If inv is asserted during WAIT, the fill in progress SHALL still return data but SHALL leave valid cleared. inv SHALL win over a simultaneous fill.
REQ-023 rdy_x, data_x, sdr_req and sdr_addr SHALL change only as stated above.

Reset
REQ-024 While reset_n is low, the block SHALL hold:
- state IDLE, pointer = a;
- all valid bits 0;
- rdy_a..d = 0, data_a..d = 0;
- sdr_req = 0, sdr_addr = 0.
REQ-025 Reset mid-WAIT SHALL abandon the fill with no rdy toggle; the SDRAM controller is reset in the same domain so that sdr_rdy returns to 0.

Verification
REQ-026 Port a req 0->1, addr_a=22'h000004, BASE=0; SDRAM returns 64'h11112222_33334444 after 5 clocks -> sdr_addr=25'h10, sdr_req 0->1, data_a=32'h33334444, rdy_a=1.
REQ-027 After REQ-026, port a req 1->0 with addr_a=22'h000005 -> no sdr_req toggle, data_a=32'h11112222 and rdy_a=0 one clock later.
REQ-028 Ports a, b, c, d toggle req in the same cycle, all misses -> sdr_req toggles in order a, b, c, d, and each rdy toggles once.
REQ-029 Repeat REQ-027 with inv pulsed one clock before -> miss, sdr_req toggles, and data equals new sdr_data.
REQ-030 Assert reset_n low during WAIT, then release -> outputs match REQ-024, and no rdy toggles for the abandoned request.
REQ-031 BASE=25'h1FFFFF8, addr_b=22'h000002 -> sdr_addr=25'h0000000 (wrap).

Source files
------------

// File: rtl/ga23_rom_arb.sv
// Four-port tile ROM arbiter: each port keeps a single 64-bit line cache and
// misses are served one at a time from SDRAM over a toggle handshake.
module ga23_rom_arb #(
    parameter logic [24:0] BASE = 25'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inv,
    input  logic [21:0] addr_a,
    input  logic [21:0] addr_b,
    input  logic [21:0] addr_c,
    input  logic [21:0] addr_d,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        req_c,
    input  logic        req_d,
    output logic        rdy_a,
    output logic        rdy_b,
    output logic        rdy_c,
    output logic        rdy_d,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic [31:0] data_c,
    output logic [31:0] data_d,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    input  logic [63:0] sdr_data
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  ptr_reg, ptr_next;
    logic [1:0]  cur_port_reg, cur_port_next;
    logic        cur_half_reg, cur_half_next;
    logic [20:0] cur_tag_reg, cur_tag_next;
    logic        inv_seen_reg, inv_seen_next;
    logic        sdr_req_reg, sdr_req_next;
    logic [24:0] sdr_addr_reg, sdr_addr_next;

    logic [3:0]  valid_reg, valid_next;
    logic [3:0]  rdy_reg, rdy_next;
    logic [31:0] data_reg [4];
    logic [31:0] data_next [4];
    logic [20:0] tag_reg [4];
    logic [63:0] line_reg [4];
    logic [3:0]  fill_we;

    logic [21:0] addr_arr [4];
    logic [3:0]  req_vec;
    logic [3:0]  pending;
    logic [3:0]  hit;

    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;

    assign addr_arr[0] = addr_a;
    assign addr_arr[1] = addr_b;
    assign addr_arr[2] = addr_c;
    assign addr_arr[3] = addr_d;
    assign req_vec     = {req_d, req_c, req_b, req_a};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign pending[gi] = req_vec[gi] ^ rdy_reg[gi];
            assign hit[gi]     = valid_reg[gi] && (tag_reg[gi] == addr_arr[gi][21:1]);
        end
    endgenerate

    // Round-robin search starting at the port after the last one served.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_reg;
        cand        = ptr_reg;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_reg + 2'(k);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        cur_port_next = cur_port_reg;
        cur_half_next = cur_half_reg;
        cur_tag_next  = cur_tag_reg;
        inv_seen_next = inv_seen_reg;
        sdr_req_next  = sdr_req_reg;
        sdr_addr_next = sdr_addr_reg;
        valid_next    = valid_reg;
        rdy_next      = rdy_reg;
        fill_we       = '0;
        for (int i = 0; i < 4; i++) begin
            data_next[i] = data_reg[i];
        end

        case (state_reg)
            S_IDLE: begin
                if (grant_found) begin
                    if (hit[grant_idx]) begin
                        data_next[grant_idx] = addr_arr[grant_idx][0] ? line_reg[grant_idx][63:32]
                                                                       : line_reg[grant_idx][31:0];
                        rdy_next[grant_idx]  = ~rdy_reg[grant_idx];
                        ptr_next             = grant_idx + 2'd1;
                    end else begin
                        sdr_addr_next = BASE + {1'b0, addr_arr[grant_idx][21:1], 3'b000};
                        sdr_req_next  = ~sdr_req_reg;
                        cur_port_next = grant_idx;
                        cur_half_next = addr_arr[grant_idx][0];
                        cur_tag_next  = addr_arr[grant_idx][21:1];
                        inv_seen_next = 1'b0;
                        state_next    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (inv) begin
                    inv_seen_next = 1'b1;
                end
                if (sdr_rdy == sdr_req_reg) begin
                    // A fill overtaken by an invalidate still answers, but is not cached.
                    fill_we[cur_port_reg]    = 1'b1;
                    valid_next[cur_port_reg] = ~inv_seen_reg;
                    data_next[cur_port_reg]  = cur_half_reg ? sdr_data[63:32] : sdr_data[31:0];
                    rdy_next[cur_port_reg]   = ~rdy_reg[cur_port_reg];
                    ptr_next                 = cur_port_reg + 2'd1;
                    state_next               = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (inv) begin
            valid_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            cur_port_reg <= '0;
            cur_half_reg <= 1'b0;
            cur_tag_reg  <= '0;
            inv_seen_reg <= 1'b0;
            sdr_req_reg  <= 1'b0;
            sdr_addr_reg <= '0;
            valid_reg    <= '0;
            rdy_reg      <= '0;
            for (int i = 0; i < 4; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cur_port_reg <= cur_port_next;
            cur_half_reg <= cur_half_next;
            cur_tag_reg  <= cur_tag_next;
            inv_seen_reg <= inv_seen_next;
            sdr_req_reg  <= sdr_req_next;
            sdr_addr_reg <= sdr_addr_next;
            valid_reg    <= valid_next;
            rdy_reg      <= rdy_next;
            for (int i = 0; i < 4; i++) begin
                data_reg[i] <= data_next[i];
            end
        end
    end

    // Line storage carries no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fill_we[i]) begin
                line_reg[i] <= sdr_data;
                tag_reg[i]  <= cur_tag_reg;
            end
        end
    end

    assign rdy_a    = rdy_reg[0];
    assign rdy_b    = rdy_reg[1];
    assign rdy_c    = rdy_reg[2];
    assign rdy_d    = rdy_reg[3];
    assign data_a   = data_reg[0];
    assign data_b   = data_reg[1];
    assign data_c   = data_reg[2];
    assign data_d   = data_reg[3];
    assign sdr_addr = sdr_addr_reg;
    assign sdr_req  = sdr_req_reg;

endmodule

// File: tb/tb_ga23_rom_arb.sv
// Bench for ga23_rom_arb: directed vector table, hand-built corner sequences,
// and randomized batches against a per-port line-cache reference model.
module tb_ga23_rom_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        inv;
    logic [21:0] addr [4];
    logic        req [4];
    logic        rdy [4];
    logic [31:0] data [4];
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_rdy;
    logic [63:0] sdr_data;

    logic [21:0] w_addr_b;
    logic        w_req_b;
    logic        w_rdy [4];
    logic [31:0] w_data [4];
    logic [24:0] w_sdr_addr;
    logic        w_sdr_req;

    ga23_rom_arb #(.BASE(25'h0)) dut (
        .clk(clk), .reset_n(reset_n), .inv(inv),
        .addr_a(addr[0]), .addr_b(addr[1]), .addr_c(addr[2]), .addr_d(addr[3]),
        .req_a(req[0]), .req_b(req[1]), .req_c(req[2]), .req_d(req[3]),
        .rdy_a(rdy[0]), .rdy_b(rdy[1]), .rdy_c(rdy[2]), .rdy_d(rdy[3]),
        .data_a(data[0]), .data_b(data[1]), .data_c(data[2]), .data_d(data[3]),
        .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_rdy(sdr_rdy), .sdr_data(sdr_data)
    );

    ga23_rom_arb #(.BASE(25'h1FFFFF8)) dut_w (
        .clk(clk), .reset_n(reset_n), .inv(1'b0),
        .addr_a(22'h0), .addr_b(w_addr_b), .addr_c(22'h0), .addr_d(22'h0),
        .req_a(1'b0), .req_b(w_req_b), .req_c(1'b0), .req_d(1'b0),
        .rdy_a(w_rdy[0]), .rdy_b(w_rdy[1]), .rdy_c(w_rdy[2]), .rdy_d(w_rdy[3]),
        .data_a(w_data[0]), .data_b(w_data[1]), .data_c(w_data[2]), .data_d(w_data[3]),
        .sdr_addr(w_sdr_addr), .sdr_req(w_sdr_req), .sdr_rdy(1'b0), .sdr_data(64'h0)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // SDRAM contents: a fixed line for directed vectors, else an address/generation pattern.
    int          lat;
    int          gen;
    logic        use_fixed;
    logic [63:0] fixed_line;

    function automatic logic [63:0] mem_line(input logic [24:0] a, input int g);
        logic [31:0] hi;
        hi = {g[6:0], a};
        return {hi, hi ^ 32'h5A5AC3C3};
    endfunction

    function automatic logic [24:0] baddr(input logic [21:0] a);
        return {1'b0, a[21:1], 3'b000};
    endfunction

    function automatic logic [31:0] half(input logic [63:0] l, input logic s);
        return s ? l[63:32] : l[31:0];
    endfunction

    initial begin : responder
        int cnt;
        cnt = 0;
        sdr_rdy = 1'b0;
        sdr_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                sdr_rdy = 1'b0;
                cnt = 0;
            end else if (sdr_req != sdr_rdy) begin
                if (cnt >= lat) begin
                    sdr_data = use_fixed ? fixed_line : mem_line(sdr_addr, gen);
                    sdr_rdy = sdr_req;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    int          sdr_toggles;
    logic [24:0] sdr_log [$];
    int          rdy_cnt [4];

    initial begin : monitor
        logic sp;
        logic rp [4];
        sdr_toggles = 0;
        sp = 1'b0;
        for (int p = 0; p < 4; p++) begin
            rdy_cnt[p] = 0;
            rp[p] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                if (sdr_req !== sp) begin
                    sdr_toggles++;
                    sdr_log.push_back(sdr_addr);
                end
                for (int p = 0; p < 4; p++) begin
                    if (rdy[p] !== rp[p]) rdy_cnt[p]++;
                end
            end
            sp = sdr_req;
            for (int p = 0; p < 4; p++) rp[p] = rdy[p];
        end
    end

    function automatic bit all_served();
        for (int p = 0; p < 4; p++) begin
            if (rdy[p] !== req[p]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_txn(input int p, input logic [21:0] a, output int cycles, output int sdr_d);
        int s0;
        s0 = sdr_toggles;
        addr[p] = a;
        req[p] = ~req[p];
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (rdy[p] !== req[p] && cycles < 100);
        sdr_d = sdr_toggles - s0;
    endtask

    typedef struct {
        int          port;
        logic [21:0] a;
        bit          inv_before;
        logic [63:0] line;
        bit          exp_miss;
        logic [24:0] exp_sa;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [11];

    bit          m_valid [4];
    logic [20:0] m_tag [4];
    logic [63:0] m_line [4];

    initial begin
        int cyc, sd, s0, r0[4], guard, misses;
        logic [3:0]  mask;
        logic [21:0] a;
        logic [31:0] expd [4];

        tbl[0]  = '{0, 22'h000004, 0, 64'h11112222_33334444, 1, 25'h10,     32'h33334444};
        tbl[1]  = '{0, 22'h000005, 0, 64'hDEADBEEF_DEADBEEF, 0, 25'h0,      32'h11112222};
        tbl[2]  = '{0, 22'h000005, 1, 64'hAAAABBBB_CCCCDDDD, 1, 25'h10,     32'hAAAABBBB};
        tbl[3]  = '{1, 22'h000002, 0, 64'h01234567_89ABCDEF, 1, 25'h8,      32'h89ABCDEF};
        tbl[4]  = '{1, 22'h000003, 0, 64'hDEADBEEF_DEADBEEF, 0, 25'h0,      32'h01234567};
        tbl[5]  = '{0, 22'h000004, 0, 64'hDEADBEEF_DEADBEEF, 0, 25'h0,      32'hCCCCDDDD};
        tbl[6]  = '{2, 22'h3FFFFF, 0, 64'h76543210_FEDCBA98, 1, 25'hFFFFF8, 32'h76543210};
        tbl[7]  = '{3, 22'h000000, 0, 64'h0F0F0F0F_F0F0F0F0, 1, 25'h0,      32'hF0F0F0F0};
        tbl[8]  = '{3, 22'h000001, 1, 64'h12121212_34343434, 1, 25'h0,      32'h12121212};
        tbl[9]  = '{2, 22'h3FFFFE, 0, 64'h55556666_77778888, 1, 25'hFFFFF8, 32'h77778888};
        tbl[10] = '{1, 22'h000002, 0, 64'h9999AAAA_BBBBCCCC, 1, 25'h8,      32'hBBBBCCCC};

        reset_n = 1'b0;
        inv = 1'b0;
        use_fixed = 1'b1;
        fixed_line = '0;
        lat = 4;
        gen = 0;
        w_addr_b = 22'h0;
        w_req_b = 1'b0;
        for (int p = 0; p < 4; p++) begin
            addr[p] = '0;
            req[p] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("reset_rdy%0d", p), rdy[p], 0);
            chk($sformatf("reset_data%0d", p), data[p], 0);
        end
        chk("reset_sdr_req", sdr_req, 0);
        chk("reset_sdr_addr", sdr_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Address wrap with BASE near the top of the space
        w_addr_b = 22'h000002;
        w_req_b = 1'b1;
        @(negedge clk);
        chk("wrap_sdr_addr", w_sdr_addr, 25'h0);
        chk("wrap_sdr_req", w_sdr_req, 1);
        $display("txn wrap: sdr_addr=%h sdr_req=%0d", w_sdr_addr, w_sdr_req);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            lat = 4;
            if (tbl[i].inv_before) begin
                inv = 1'b1;
                @(negedge clk);
                inv = 1'b0;
            end
            fixed_line = tbl[i].line;
            do_txn(tbl[i].port, tbl[i].a, cyc, sd);
            $display("txn vec%0d: port=%0d addr=%h data=%h sdr_toggles=%0d cycles=%0d",
                     i, tbl[i].port, tbl[i].a, data[tbl[i].port], sd, cyc);
            chk($sformatf("vec%0d_served", i), rdy[tbl[i].port], req[tbl[i].port]);
            chk($sformatf("vec%0d_sdr_toggles", i), sd, tbl[i].exp_miss ? 1 : 0);
            chk($sformatf("vec%0d_data", i), data[tbl[i].port], tbl[i].exp_data);
            if (tbl[i].exp_miss) begin
                chk($sformatf("vec%0d_sdr_addr", i), sdr_addr, tbl[i].exp_sa);
                chk($sformatf("vec%0d_miss_latency", i), cyc, lat + 2);
            end else begin
                chk($sformatf("vec%0d_hit_latency", i), cyc, 1);
            end
        end

        // Reset in the middle of a fill
        lat = 20;
        s0 = sdr_toggles;
        addr[0] = 22'h000040;
        req[0] = ~req[0];
        repeat (3) @(negedge clk);
        chk("midwait_sdr_toggled", sdr_toggles - s0, 1);
        for (int p = 0; p < 4; p++) r0[p] = rdy_cnt[p];
        reset_n = 1'b0;
        w_req_b = 1'b0;
        for (int p = 0; p < 4; p++) req[p] = 1'b0;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("midrst_rdy%0d", p), rdy[p], 0);
            chk($sformatf("midrst_data%0d", p), data[p], 0);
        end
        chk("midrst_sdr_req", sdr_req, 0);
        chk("midrst_sdr_addr", sdr_addr, 0);
        reset_n = 1'b1;
        lat = 1;
        s0 = sdr_toggles;
        repeat (25) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("postrst_rdy_toggles%0d", p), rdy_cnt[p] - r0[p], 0);
            chk($sformatf("postrst_rdy%0d", p), rdy[p], 0);
        end
        chk("postrst_sdr_toggles", sdr_toggles - s0, 0);
        chk("postrst_sdr_req", sdr_req, 0);
        $display("txn reset_mid_wait: sdr_req=%0d rdy_a=%0d", sdr_req, rdy[0]);

        // All four ports miss together: served a, b, c, d
        use_fixed = 1'b0;
        gen = 1;
        s0 = sdr_log.size();
        for (int p = 0; p < 4; p++) begin
            r0[p] = rdy_cnt[p];
            addr[p] = 22'h000100 * 22'(p + 1);
        end
        for (int p = 0; p < 4; p++) req[p] = ~req[p];
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!all_served() && guard < 100);
        chk("rr_all_served", all_served(), 1);
        chk("rr_sdr_count", sdr_log.size() - s0, 4);
        for (int p = 0; p < 4; p++) begin
            if (sdr_log.size() > s0 + p) chk($sformatf("rr_order%0d", p), sdr_log[s0 + p], baddr(addr[p]));
            chk($sformatf("rr_rdy_once%0d", p), rdy_cnt[p] - r0[p], 1);
            chk($sformatf("rr_data%0d", p), data[p], half(mem_line(baddr(addr[p]), gen), addr[p][0]));
        end
        $display("txn rr4: sdr_requests=%0d cycles=%0d", sdr_log.size() - s0, guard);

        // Invalidate during a fill: data returned, line left invalid
        lat = 6;
        s0 = sdr_toggles;
        addr[3] = 22'h000010;
        req[3] = ~req[3];
        repeat (2) @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        guard = 0;
        while (rdy[3] !== req[3] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("invwait_served", rdy[3], req[3]);
        chk("invwait_data", data[3], half(mem_line(baddr(22'h10), gen), 1'b0));
        chk("invwait_sdr", sdr_toggles - s0, 1);
        do_txn(3, 22'h000011, cyc, sd);
        chk("invwait_refetch", sd, 1);
        chk("invwait_refetch_data", data[3], half(mem_line(baddr(22'h11), gen), 1'b1));
        do_txn(3, 22'h000010, cyc, sd);
        chk("invwait_then_hit", sd, 0);
        chk("invwait_hit_data", data[3], half(mem_line(baddr(22'h10), gen), 1'b0));
        $display("txn inv_during_wait: data_d=%h", data[3]);

        // Randomized batches against the line-cache model
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        for (int p = 0; p < 4; p++) m_valid[p] = 1'b0;
        for (int b = 0; b < 40; b++) begin
            lat = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) gen++;
            if ($urandom_range(0, 3) == 0) begin
                inv = 1'b1;
                @(negedge clk);
                inv = 1'b0;
                for (int p = 0; p < 4; p++) m_valid[p] = 1'b0;
            end
            mask = 4'($urandom_range(1, 15));
            misses = 0;
            s0 = sdr_toggles;
            for (int p = 0; p < 4; p++) begin
                r0[p] = rdy_cnt[p];
                expd[p] = data[p];
                if (mask[p]) begin
                    a = 22'($urandom_range(0, 7));
                    addr[p] = a;
                    if (!(m_valid[p] && m_tag[p] == a[21:1])) begin
                        m_line[p] = mem_line(baddr(a), gen);
                        m_tag[p] = a[21:1];
                        m_valid[p] = 1'b1;
                        misses++;
                    end
                    expd[p] = half(m_line[p], a[0]);
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (mask[p]) req[p] = ~req[p];
            end
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!all_served() && guard < 200);
            chk($sformatf("rnd%0d_served", b), all_served(), 1);
            chk($sformatf("rnd%0d_sdr", b), sdr_toggles - s0, misses);
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("rnd%0d_data%0d", b, p), data[p], expd[p]);
                chk($sformatf("rnd%0d_rdy%0d", b, p), rdy_cnt[p] - r0[p], mask[p] ? 1 : 0);
            end
            $display("txn rnd%0d: mask=%b misses=%0d cycles=%0d", b, mask, misses, guard);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
